// File: rtl/reg_bank_pkg.sv
// Shared op-code and controller state encodings for the register bank cell.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_INC     = 3'd1,
    OP_DEC     = 3'd2,
    OP_PTR_INC = 3'd3,
    OP_PTR_DEC = 3'd4,
    OP_LOAD    = 3'd5,
    OP_CLR     = 3'd6,
    OP_CLR_ALL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/reg_word_cell.sv
// One storage word: plain enable-loaded register with async active-low clear.
module reg_word_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank_cell.sv
// Pointer-addressed bank of counter cells with a multi-cycle clear-all sweep.
// state    | meaning
// ST_IDLE  | accepts one op per cycle, op_ready high
// ST_SWEEP | clears one cell per cycle, ops ignored, op_ready low
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic             op_ready,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W-1:0] ptr,
  output logic             zero,
  output logic             wrap
);

  state_e           r_state;
  logic [PTR_W-1:0] r_sweep_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic             r_wrap;

  op_e              w_op;
  logic             w_accept;
  logic [WIDTH-1:0] w_cell [DEPTH];
  logic [DEPTH-1:0] w_cell_en;
  logic [WIDTH-1:0] w_cell_d;
  logic [WIDTH-1:0] w_cur;
  logic             w_cell_op;
  logic             w_wrap_nxt;

  assign w_op     = op_e'(op);
  assign op_ready = (r_state == ST_IDLE);
  assign w_accept = op_valid & op_ready;
  assign w_cur    = w_cell[r_ptr];

  always_comb begin
    w_cell_d   = '0;
    w_cell_op  = 1'b0;
    w_wrap_nxt = 1'b0;
    if (w_accept) begin
      case (w_op)
        OP_INC: begin
          w_cell_d   = w_cur + WIDTH'(1);
          w_cell_op  = 1'b1;
          w_wrap_nxt = &w_cur;
        end
        OP_DEC: begin
          w_cell_d   = w_cur - WIDTH'(1);
          w_cell_op  = 1'b1;
          w_wrap_nxt = ~|w_cur;
        end
        OP_LOAD: begin
          w_cell_d  = din;
          w_cell_op = 1'b1;
        end
        OP_CLR:     w_cell_op  = 1'b1;
        OP_PTR_INC: w_wrap_nxt = &r_ptr;
        OP_PTR_DEC: w_wrap_nxt = ~|r_ptr;
        default: ;
      endcase
    end
  end

  // During a sweep the shared data bus is already zero; only the enable moves.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign w_cell_en[i] = (r_state == ST_SWEEP) ? (r_sweep_cnt == PTR_W'(i))
                                                : (w_cell_op && (r_ptr == PTR_W'(i)));
    reg_word_cell #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en (w_cell_en[i]),
      .i_d  (w_cell_d),
      .o_q  (w_cell[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sweep_cnt <= '0;
      r_ptr       <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_PTR_INC: r_ptr <= r_ptr + PTR_W'(1);
              OP_PTR_DEC: r_ptr <= r_ptr - PTR_W'(1);
              OP_CLR_ALL: begin
                r_state     <= ST_SWEEP;
                r_sweep_cnt <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_SWEEP: begin
          if (r_sweep_cnt == PTR_W'(DEPTH - 1)) begin
            r_state     <= ST_IDLE;
            r_sweep_cnt <= '0;
            r_ptr       <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + PTR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout = w_cur;
  assign ptr  = r_ptr;
  assign zero = (w_cur == '0);
  assign wrap = r_wrap;

endmodule

// File: tb/tb_reg_bank_cell.sv
// Scoreboard bench for reg_bank_cell, run on an 8x16 and a 4x4 instance side by side.
module tb_reg_bank_cell;

  typedef struct {
    int dout;
    int ptr;
    bit zero;
    bit wrap;
    bit ready;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int W    = (g == 0) ? 8 : 4;
    localparam int D    = (g == 0) ? 16 : 4;
    localparam int PW   = $clog2(D);
    localparam int MAXV = (1 << W) - 1;

    logic          rst_n;
    logic          op_valid;
    logic [2:0]    op;
    logic [W-1:0]  din;
    logic          op_ready;
    logic [W-1:0]  dout;
    logic [PW-1:0] ptr;
    logic          zero;
    logic          wrap;

    reg_bank_cell #(
      .WIDTH(W),
      .DEPTH(D)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .op_valid(op_valid),
      .op      (op),
      .din     (din),
      .op_ready(op_ready),
      .dout    (dout),
      .ptr     (ptr),
      .zero    (zero),
      .wrap    (wrap)
    );

    // Reference: array of cells, a pointer, and the number of sweep cycles still owed.
    int   m_mem [D];
    int   m_ptr;
    int   m_busy;
    exp_t q[$];

    task automatic reset_model();
      foreach (m_mem[i]) m_mem[i] = 0;
      m_ptr  = 0;
      m_busy = 0;
    endtask

    task automatic step(input bit v, input int o, input int d);
      exp_t e;
      op_valid = v;
      op       = 3'(o);
      din      = W'(d);
      e.wrap   = 1'b0;
      if (m_busy > 0) begin
        m_mem[D - m_busy] = 0;
        m_busy--;
        if (m_busy == 0) m_ptr = 0;
      end else if (v) begin
        case (o)
          1: begin
            e.wrap = (m_mem[m_ptr] + 1) > MAXV;
            m_mem[m_ptr] = (m_mem[m_ptr] + 1) % (MAXV + 1);
          end
          2: begin
            e.wrap = (m_mem[m_ptr] == 0);
            m_mem[m_ptr] = (m_mem[m_ptr] + MAXV) % (MAXV + 1);
          end
          3: begin
            e.wrap = (m_ptr + 1) >= D;
            m_ptr  = (m_ptr + 1) % D;
          end
          4: begin
            e.wrap = (m_ptr == 0);
            m_ptr  = (m_ptr + D - 1) % D;
          end
          5: m_mem[m_ptr] = d & MAXV;
          6: m_mem[m_ptr] = 0;
          7: m_busy = D;
          default: ;
        endcase
      end
      e.dout  = m_mem[m_ptr];
      e.ptr   = m_ptr;
      e.zero  = (e.dout == 0);
      e.ready = (m_busy == 0);
      q.push_back(e);
      @(negedge clk);
    endtask

    task automatic load_distinct();
      for (int i = 0; i < D; i++) begin
        step(1, 5, (i * 7 + 1) & MAXV);
        step(1, 3, 0);
      end
    endtask

    task automatic walk();
      for (int i = 0; i < D; i++) step(1, 3, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
      chk($sformatf("c%0d_%s_dout", g, tag), int'(dout), 0);
      chk($sformatf("c%0d_%s_zero", g, tag), int'(zero), 1);
      chk($sformatf("c%0d_%s_ready", g, tag), int'(op_ready), 1);
      chk($sformatf("c%0d_%s_ptr", g, tag), int'(ptr), 0);
      chk($sformatf("c%0d_%s_wrap", g, tag), int'(wrap), 0);
    endtask

    initial begin : mon
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("c%0d_dout", g), int'(dout), e.dout);
          chk($sformatf("c%0d_ptr", g), int'(ptr), e.ptr);
          chk($sformatf("c%0d_zero", g), int'(zero), int'(e.zero));
          chk($sformatf("c%0d_wrap", g), int'(wrap), int'(e.wrap));
          chk($sformatf("c%0d_ready", g), int'(op_ready), int'(e.ready));
        end
      end
    end

    initial begin : drv
      int cnt;
      int guard;
      int r;
      int k;
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op       = 3'd0;
      din      = '0;
      reset_model();
      @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;

      // Increment from reset, then arithmetic wrap both ways.
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 1, 0);
      chk($sformatf("c%0d_inc3", g), int'(dout), 3);
      step(1, 5, MAXV);
      step(1, 1, 0);
      chk($sformatf("c%0d_incwrap_zero", g), int'(zero), 1);
      step(0, 0, 0);
      step(1, 2, 0);
      chk($sformatf("c%0d_decwrap_dout", g), int'(dout), MAXV);
      step(0, 0, 0);
      step(1, 5, 0);
      step(1, 6, 0);

      // Pointer wrap both ways.
      step(1, 4, 0);
      chk($sformatf("c%0d_ptrdec", g), int'(ptr), D - 1);
      step(1, 3, 0);
      step(0, 0, 0);

      // Clear-all with ops offered during the sweep.
      load_distinct();
      for (int i = 0; i < 5; i++) step(1, 3, 0);
      step(1, 7, 0);
      cnt   = 0;
      guard = 0;
      while (op_ready == 1'b0 && guard < 100) begin
        cnt++;
        guard++;
        step(1, $urandom_range(0, 7), $urandom);
      end
      chk($sformatf("c%0d_sweep_len", g), cnt, D);
      walk();

      // Randomised traffic, clear-all kept rare.
      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(0, 31);
        step($urandom_range(0, 3) != 0, (r == 0) ? 7 : r % 7, $urandom);
      end
      guard = 0;
      while (m_busy > 0 && guard < 100) begin
        guard++;
        step(0, 0, 0);
      end

      // Reset asserted between edges in the middle of a sweep.
      load_distinct();
      step(1, 7, 0);
      k = (D > 8) ? 7 : D - 2;
      for (int i = 0; i < k; i++) step(1, 1, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midsweep");
      q.delete();
      reset_model();
      op_valid = 1'b1;
      op       = 3'd1;
      @(negedge clk);
      chk_reset_outputs("held");
      rst_n = 1'b1;
      step(1, 1, 0);
      chk($sformatf("c%0d_first_op", g), int'(dout), 1);
      step(1, 2, 0);
      walk();
      step(0, 0, 0);
      n_done++;
    end
  end

  initial begin
    wait (n_done == 2);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
